// File: rtl/drop_pkg.sv
// Shared definitions for the baggage-drop sequencer: FSM state encodings,
// result codes and the timer width helper.
package drop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EVAL     = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_FINISH   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        RES_NONE    = 3'd0,
        RES_DROP    = 3'd1,
        RES_HOT     = 3'd2,
        RES_COLD    = 3'd3,
        RES_EMPTY   = 3'd4,
        RES_ABORTED = 3'd5
    } result_e;

    // Width needed to hold the longer of the two phase lengths, plus one bit.
    function automatic int tmr_width(input int rel_cycles, input int cool_cycles);
        int longest;
        if (rel_cycles > cool_cycles) begin
            longest = rel_cycles;
        end else begin
            longest = cool_cycles;
        end
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/drop_timer.sv
// Loadable down-counter with a zero flag; shared by the RELEASE and COOLDOWN
// phases of the drop sequencer.
module drop_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/drop_sequencer.sv
// Sequences one baggage-drop attempt: freezes sensor inputs for the external
// display_and_drop datapath, pulses the release actuator, then cools down.
module drop_sequencer
    import drop_pkg::*;
#(
    parameter int RELEASE_CYCLES  = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int MAX_DROPS       = 15,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             reload,
    input  logic             abort,
    input  logic [15:0]      t_act,
    input  logic [15:0]      t_lim,
    input  logic             drop_en,
    input  logic             drop_activated,
    output logic [15:0]      t_act_q,
    output logic [15:0]      t_lim_q,
    output logic             drop_en_q,
    output logic             release_pulse,
    output logic             busy,
    output logic             done,
    output logic [2:0]       result,
    output logic [CNT_W-1:0] drop_count
);

    localparam int TMR_W = tmr_width(RELEASE_CYCLES, COOLDOWN_CYCLES);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [2:0]         result_r;
    logic [2:0]         result_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [15:0]        t_act_r;
    logic [15:0]        t_lim_r;
    logic               drop_en_r;
    logic               release_r;
    logic               busy_r;
    logic               done_r;
    logic               latch_s;
    logic               tmr_load_s;
    logic [TMR_W-1:0]   tmr_val_s;
    logic               tmr_zero_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_W'(MAX_DROPS)) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    drop_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Next-state, result, counter and timer-load decisions.
    always_comb begin
        state_nxt_s  = state_r;
        result_nxt_s = result_r;
        count_nxt_s  = count_r;
        latch_s      = 1'b0;
        tmr_load_s   = 1'b0;
        tmr_val_s    = {TMR_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (reload) begin
                    count_nxt_s = {CNT_W{1'b0}};
                end else if (req) begin
                    latch_s      = 1'b1;
                    result_nxt_s = RES_NONE;
                    state_nxt_s  = ST_EVAL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EVAL: begin
                if (count_r == CNT_W'(MAX_DROPS)) begin
                    result_nxt_s = RES_EMPTY;
                    state_nxt_s  = ST_FINISH;
                end else if (drop_activated) begin
                    count_nxt_s = sat_inc(count_r);
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = TMR_W'(RELEASE_CYCLES - 1);
                    state_nxt_s = ST_RELEASE;
                end else begin
                    result_nxt_s = drop_en_r ? RES_HOT : RES_COLD;
                    state_nxt_s  = ST_FINISH;
                end
            end
            ST_RELEASE: begin
                // Abort wins even in the last release cycle.
                if (abort) begin
                    result_nxt_s = RES_ABORTED;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = TMR_W'(COOLDOWN_CYCLES - 1);
                    state_nxt_s  = ST_COOLDOWN;
                end else if (tmr_zero_s) begin
                    result_nxt_s = RES_DROP;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = TMR_W'(COOLDOWN_CYCLES - 1);
                    state_nxt_s  = ST_COOLDOWN;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            ST_COOLDOWN: begin
                if (tmr_zero_s) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_COOLDOWN;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, frozen sensor values and registered outputs derived from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            result_r  <= RES_NONE;
            count_r   <= {CNT_W{1'b0}};
            t_act_r   <= 16'd0;
            t_lim_r   <= 16'd0;
            drop_en_r <= 1'b0;
            release_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            result_r  <= result_nxt_s;
            count_r   <= count_nxt_s;
            release_r <= (state_nxt_s == ST_RELEASE);
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_FINISH);
            if (latch_s) begin
                t_act_r   <= t_act;
                t_lim_r   <= t_lim;
                drop_en_r <= drop_en;
            end else begin
                t_act_r   <= t_act_r;
                t_lim_r   <= t_lim_r;
                drop_en_r <= drop_en_r;
            end
        end
    end

    assign t_act_q       = t_act_r;
    assign t_lim_q       = t_lim_r;
    assign drop_en_q     = drop_en_r;
    assign release_pulse = release_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign result        = result_r;
    assign drop_count    = count_r;

endmodule

// File: tb/tb_drop_sequencer.sv
// Scoreboard bench for drop_sequencer; display_and_drop is modelled from the
// frozen *_q outputs.
module tb_drop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, reload, abort;
    logic [15:0] t_act, t_lim;
    logic        drop_en;
    logic        drop_activated;
    logic [15:0] t_act_q, t_lim_q;
    logic        drop_en_q;
    logic        release_pulse, busy, done;
    logic [2:0]  result;
    logic [3:0]  drop_count;

    typedef struct {
        logic [2:0]  res;
        logic [3:0]  cnt;
        int          rel;
        int          lat;
        logic [15:0] ta;
        logic [15:0] tl;
        logic        en;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_cnt = 0;

    drop_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .reload         (reload),
        .abort          (abort),
        .t_act          (t_act),
        .t_lim          (t_lim),
        .drop_en        (drop_en),
        .drop_activated (drop_activated),
        .t_act_q        (t_act_q),
        .t_lim_q        (t_lim_q),
        .drop_en_q      (drop_en_q),
        .release_pulse  (release_pulse),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .drop_count     (drop_count)
    );

    assign drop_activated = drop_en_q && (t_act_q <= t_lim_q);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: measures each attempt and compares against the scoreboard on done.
    initial begin
        int   start = 0;
        int   rel_cnt = 0;
        logic prev_busy = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
                rel_cnt   = 0;
            end else begin
                if (busy && !prev_busy) begin
                    start   = cyc;
                    rel_cnt = 0;
                end
                if (release_pulse) rel_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 32'(result), 32'(e.res));
                        chk("drop_count", 32'(drop_count), 32'(e.cnt));
                        chk("release_cycles", 32'(rel_cnt), 32'(e.rel));
                        chk("latency", 32'(cyc - start + 1), 32'(e.lat));
                        chk("t_act_q", 32'(t_act_q), 32'(e.ta));
                        chk("t_lim_q", 32'(t_lim_q), 32'(e.tl));
                        chk("drop_en_q", 32'(drop_en_q), 32'(e.en));
                    end
                end
                prev_busy = busy;
            end
        end
    end

    // abort_mode: 0 none, 1 assert in 2nd release cycle, 2 held for whole attempt.
    task automatic do_req(input logic [15:0] ta, input logic [15:0] tl, input logic en,
                          input logic [2:0] exp_res, input int exp_rel,
                          input int abort_mode, input bit wiggle);
        exp_t e;
        bit   finished = 1'b0;
        if (exp_rel > 0 && exp_cnt < 15) exp_cnt++;
        e.res = exp_res;
        e.cnt = 4'(exp_cnt);
        e.rel = exp_rel;
        e.lat = (exp_rel > 0) ? (2 + exp_rel + 8) : 2;
        e.ta  = ta;
        e.tl  = tl;
        e.en  = en;
        sb.push_back(e);
        @(posedge clk); #2;
        t_act = ta; t_lim = tl; drop_en = en; req = 1'b1;
        abort = (abort_mode == 2);
        @(posedge clk); #2;
        req = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #2;
            if (abort_mode == 1) abort = (i == 2);
            if (wiggle) begin
                t_act   = ~t_act;
                drop_en = ~drop_en;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        abort = 1'b0;
        if (!finished) chk("attempt_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; req = 1'b0; reload = 1'b0; abort = 1'b0;
        t_act = 16'd0; t_lim = 16'd0; drop_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_release", 32'(release_pulse), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_count", 32'(drop_count), 32'd0);
        chk("rst_t_act_q", 32'(t_act_q), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // 1..3: drop, hot (abort held, ignored), cold, equal-time drop
        do_req(16'd100, 16'd200, 1'b1, 3'd1, 4, 0, 1'b0);
        do_req(16'd300, 16'd200, 1'b1, 3'd2, 0, 2, 1'b0);
        do_req(16'd100, 16'd200, 1'b0, 3'd3, 0, 0, 1'b0);
        do_req(16'd50,  16'd50,  1'b1, 3'd1, 4, 0, 1'b0);

        // 4: fill the magazine, then empty, reload+req, drop
        while (exp_cnt < 15) do_req(16'd10, 16'd20, 1'b1, 3'd1, 4, 0, 1'b0);
        do_req(16'd10, 16'd20, 1'b1, 3'd4, 0, 0, 1'b0);
        @(posedge clk); #2;
        reload = 1'b1; req = 1'b1;
        @(posedge clk); #2;
        reload = 1'b0; req = 1'b0;
        chk("reload_req_busy", 32'(busy), 32'd0);
        chk("reload_count", 32'(drop_count), 32'd0);
        exp_cnt = 0;
        do_req(16'd10, 16'd20, 1'b1, 3'd1, 4, 0, 1'b0);

        // 5: abort in 2nd release cycle, then reset mid-release
        do_req(16'd10, 16'd20, 1'b1, 3'd5, 2, 1, 1'b0);
        @(posedge clk); #2;
        t_act = 16'd1; t_lim = 16'd2; drop_en = 1'b1; req = 1'b1;
        @(posedge clk); #2;
        req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (release_pulse) begin
                seen = 1'b1;
                break;
            end
        end
        chk("release_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_release", 32'(release_pulse), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_count", 32'(drop_count), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_cnt = 0;

        // 6: sensor inputs toggling while busy
        do_req(16'd100, 16'd200, 1'b1, 3'd1, 4, 0, 1'b1);
        do_req(16'd300, 16'd200, 1'b1, 3'd2, 0, 0, 1'b1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
